demux2_reg: RTL and testbench

//  Registered 1-to-2 demultiplexer: the distribution counterpart of mux2. It steers one

---
 rtl/demux2_reg_pkg.sv | 23 ++
 rtl/demux2_reg_if.sv | 44 ++++
 rtl/demux2_reg_out_slot.sv | 69 ++++++
 rtl/demux2_reg.sv | 55 +++++
 tb/tb_demux2_reg.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux2_reg_pkg.sv
// ----------------------------------------------------------------------------
// demux2_reg_pkg
// Shared constants for the registered 1-to-2 demultiplexer.
//   SEL_D0 / SEL_D1 : select encodings (0 -> output 0, 1 -> output 1).
//   WIDTH_DEF       : default data width.
//   CNT_W_DEF       : default transfer-counter width.
//   slot_free()     : a one-entry slot can take a new beat this cycle.
// ----------------------------------------------------------------------------
package demux2_reg_pkg;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // A slot is free when empty, or when its current beat leaves on this
    // same edge (which lets a drain and a load overlap for full throughput).
    function automatic logic slot_free(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/demux2_reg_if.sv
// ----------------------------------------------------------------------------
// demux2_reg_if
// Bundles the input stream, both output streams and the transfer counters.
//
// Handshake rule (all three streams): a beat transfers on a rising clock edge
// where valid and ready are both 1. The producer keeps valid and data stable
// until the transfer happens; ready may change freely and never depends on
// valid.
//
//   d_valid/d_ready/d/sel : input stream; sel picks the destination output
//   y0_valid/y0_ready/y0  : output stream 0
//   y1_valid/y1_ready/y1  : output stream 1
//   cnt0/cnt1             : completed handshakes per output (wrap-around)
//
// Modports: master = environment (source of d, sink of y0/y1),
//           slave  = demux2_reg.
// ----------------------------------------------------------------------------
interface demux2_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] d;
    logic             sel;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y0;
    logic             y1_valid;
    logic             y1_ready;
    logic [WIDTH-1:0] y1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output d_valid, d, sel, y0_ready, y1_ready,
        input  d_ready, y0_valid, y0, y1_valid, y1, cnt0, cnt1
    );

    modport slave (
        input  d_valid, d, sel, y0_ready, y1_ready,
        output d_ready, y0_valid, y0, y1_valid, y1, cnt0, cnt1
    );
endinterface

// File: rtl/demux2_reg_out_slot.sv
// ----------------------------------------------------------------------------
// out_slot
// One output of the demultiplexer: a one-entry holding register, its valid
// flag, the free indication and a wrap-around handshake counter.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : write data_i into the slot on this edge
//   data_i     : beat to store
//   ready_i    : downstream consumer accepts
//   valid_o    : slot holds a beat
//   data_o     : held beat (keeps last value after draining)
//   free_o     : slot can accept a load this cycle
//   cnt_o      : completed valid_o & ready_i handshakes, mod 2^CNT_W
// ----------------------------------------------------------------------------
module out_slot
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             drain;

    assign drain  = valid_q && ready_i;
    assign free_o = slot_free(valid_q, ready_i);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // A load wins over a drain so the slot stays full with the new beat.
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain) begin
            valid_d = 1'b0;
        end
        if (drain) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;
endmodule

// File: rtl/demux2_reg.sv
// ----------------------------------------------------------------------------
// demux2_reg
// Registered 1-to-2 demultiplexer. Each input beat goes to output 0 or 1 as
// chosen by sel; each output owns a one-entry holding register, so a stall on
// one output does not block beats bound for the other.
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset (clears both slots and counters)
//   bus   : demux2_reg_if slave modport (input stream, two output streams,
//           two transfer counters)
// Latency from input accept to output valid is one cycle; d_ready depends
// only on sel and the selected slot's valid/ready.
// ----------------------------------------------------------------------------
module demux2_reg
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    demux2_reg_if.slave  bus
);
    logic free0, free1;
    logic accept;
    logic load0, load1;

    assign bus.d_ready = (bus.sel == SEL_D1) ? free1 : free0;
    assign accept      = bus.d_valid && bus.d_ready;
    assign load0       = accept && (bus.sel == SEL_D0);
    assign load1       = accept && (bus.sel == SEL_D1);

    out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load0),
        .data_i  (bus.d),
        .ready_i (bus.y0_ready),
        .valid_o (bus.y0_valid),
        .data_o  (bus.y0),
        .free_o  (free0),
        .cnt_o   (bus.cnt0)
    );

    out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load1),
        .data_i  (bus.d),
        .ready_i (bus.y1_ready),
        .valid_o (bus.y1_valid),
        .data_o  (bus.y1),
        .free_o  (free1),
        .cnt_o   (bus.cnt1)
    );
endmodule

// File: tb/tb_demux2_reg.sv
// ----------------------------------------------------------------------------
// tb_demux2_reg
// Directed bench for demux2_reg with a per-output behavioural model and a
// negedge compare process, plus literal expectations at key points.
// ----------------------------------------------------------------------------
module tb_demux2_reg;
    localparam int W = 8;
    localparam int C = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    demux2_reg_if #(.WIDTH(W), .CNT_W(C)) bus ();

    demux2_reg #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each output is a box that holds at most one beat; m_cnt counts beats
    // that left the box. Updated at every rising edge from the inputs seen.
    logic         m_live;
    logic         m_full [2];
    logic [W-1:0] m_data [2];
    logic [C-1:0] m_cnt  [2];

    function automatic logic m_ready_now();
        int k;
        k = bus.sel ? 1 : 0;
        if (k == 0) return !m_full[0] || bus.y0_ready;
        return !m_full[1] || bus.y1_ready;
    endfunction

    initial begin
        m_live = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
            m_cnt[k]  = '0;
        end
    end

    always @(posedge clk) begin
        logic took;
        logic leaving [2];
        int   dst;
        if (reset) begin
            m_live = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
                m_cnt[k]  = '0;
            end
        end else if (m_live) begin
            took       = bus.d_valid && m_ready_now();
            dst        = bus.sel ? 1 : 0;
            leaving[0] = m_full[0] && bus.y0_ready;
            leaving[1] = m_full[1] && bus.y1_ready;
            for (int k = 0; k < 2; k++) begin
                if (leaving[k]) begin
                    m_cnt[k]  = m_cnt[k] + 1'b1;
                    m_full[k] = 1'b0;
                end
                if (took && dst == k) begin
                    m_full[k] = 1'b1;
                    m_data[k] = bus.d;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_d_ready",  32'(bus.d_ready),  32'(m_ready_now()));
            chk("cmp_y0_valid", 32'(bus.y0_valid), 32'(m_full[0]));
            chk("cmp_y1_valid", 32'(bus.y1_valid), 32'(m_full[1]));
            chk("cmp_y0",       32'(bus.y0),       32'(m_data[0]));
            chk("cmp_y1",       32'(bus.y1),       32'(m_data[1]));
            chk("cmp_cnt0",     32'(bus.cnt0),     32'(m_cnt[0]));
            chk("cmp_cnt1",     32'(bus.cnt1),     32'(m_cnt[1]));
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs read here
    // reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] data, input logic s);
        bus.d_valid = 1'b1;
        bus.d       = data;
        bus.sel     = s;
    endtask

    task automatic idle();
        bus.d_valid = 1'b0;
        bus.d       = logic'($urandom_range(0, 1)) ? 8'hxx : 8'(W'($urandom_range(0, 255)));
        bus.sel     = logic'($urandom_range(0, 1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus.d_valid  = 1'b0;
        bus.d        = '0;
        bus.sel      = 1'b0;
        bus.y0_ready = 1'b0;
        bus.y1_ready = 1'b0;

        // 1. reset
        tick();
        tick();
        chk("rst_y0_valid", 32'(bus.y0_valid), 32'd0);
        chk("rst_y1_valid", 32'(bus.y1_valid), 32'd0);
        chk("rst_y0",       32'(bus.y0),       32'h00);
        chk("rst_y1",       32'(bus.y1),       32'h00);
        chk("rst_cnt0",     32'(bus.cnt0),     32'd0);
        chk("rst_cnt1",     32'(bus.cnt1),     32'd0);
        chk("rst_d_ready",  32'(bus.d_ready),  32'd1);
        reset = 1'b0;
        bus.d = 8'h00;

        // 2. single beat to y0
        send(8'h0f, 1'b0);
        bus.y0_ready = 1'b1;
        tick();
        chk("t2_y0_valid", 32'(bus.y0_valid), 32'd1);
        chk("t2_y0",       32'(bus.y0),       32'h0f);
        chk("t2_y1_valid", 32'(bus.y1_valid), 32'd0);
        idle();
        tick();
        chk("t2_cnt0",     32'(bus.cnt0),     32'd1);
        chk("t2_y0_empty", 32'(bus.y0_valid), 32'd0);

        // 3. y1 stall, back-pressure, then release
        bus.y1_ready = 1'b0;
        send(8'hf0, 1'b1);
        tick();
        chk("t3_y1_first", 32'(bus.y1), 32'hf0);
        send(8'h5a, 1'b1);
        #1;
        chk("t3_d_ready_stall", 32'(bus.d_ready), 32'd0);
        tick();
        chk("t3_y1_hold", 32'(bus.y1), 32'hf0);
        chk("t3_y1_hold_valid", 32'(bus.y1_valid), 32'd1);
        bus.y1_ready = 1'b1;
        #1;
        chk("t3_d_ready_free", 32'(bus.d_ready), 32'd1);
        tick();
        chk("t3_y1_second", 32'(bus.y1), 32'h5a);
        chk("t3_cnt1_mid",  32'(bus.cnt1), 32'd1);
        idle();
        tick();
        chk("t3_cnt1", 32'(bus.cnt1), 32'd2);

        // 4. y1 stalled does not block y0
        bus.y1_ready = 1'b0;
        bus.y0_ready = 1'b0;
        send(8'hf0, 1'b1);
        tick();
        send(8'h3c, 1'b0);
        #1;
        chk("t4_d_ready", 32'(bus.d_ready), 32'd1);
        tick();
        chk("t4_y0",       32'(bus.y0),       32'h3c);
        chk("t4_y0_valid", 32'(bus.y0_valid), 32'd1);
        chk("t4_y1",       32'(bus.y1),       32'hf0);
        chk("t4_y1_valid", 32'(bus.y1_valid), 32'd1);
        idle();
        bus.y0_ready = 1'b1;
        bus.y1_ready = 1'b1;
        tick();
        chk("t4_cnt0", 32'(bus.cnt0), 32'd2);
        chk("t4_cnt1", 32'(bus.cnt1), 32'd3);

        // 5. back-to-back stream to y0
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b0);
            #1;
            chk("t5_d_ready", 32'(bus.d_ready), 32'd1);
            tick();
            chk("t5_y0", 32'(bus.y0), 32'(i));
        end
        idle();
        tick();
        chk("t5_cnt0", 32'(bus.cnt0), 32'd6);

        // 6. counter wrap: 249 more drains bring cnt0 to 8'hff
        for (int i = 0; i < 249; i++) begin
            send(8'($urandom_range(0, 255)), 1'b0);
            tick();
        end
        idle();
        tick();
        chk("t6_cnt0_ff", 32'(bus.cnt0), 32'hff);
        send(8'ha5, 1'b0);
        tick();
        idle();
        tick();
        chk("t6_cnt0_wrap", 32'(bus.cnt0), 32'h00);

        // reset while y0 holds a beat and another beat is accepting
        bus.y0_ready = 1'b0;
        send(8'h77, 1'b0);
        tick();
        chk("t7_y0_valid_pre", 32'(bus.y0_valid), 32'd1);
        bus.y0_ready = 1'b1;
        send(8'h88, 1'b0);
        reset = 1'b1;
        tick();
        chk("t7_y0_valid", 32'(bus.y0_valid), 32'd0);
        chk("t7_y0",       32'(bus.y0),       32'h00);
        chk("t7_cnt0",     32'(bus.cnt0),     32'd0);
        reset = 1'b0;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
